operand_fetch: RTL and testbench

Issue stage between instruction fetch and the ALU. It accepts one instruction word per transaction and drives the read side of `register_bank`. It waits out the bank's two-edge read latency, captures both operands, and presents them downstream with a valid/ready handshake. Write-backs that occur during the read window are snooped, so captured operands are never stale.

---
 rtl/risc_pkg.sv | 38 +++
 rtl/wb_snoop.sv | 51 +++++
 rtl/operand_fetch.sv | 192 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_pkg
//  Description : Shared definitions for the operand fetch stage: opcode
//                constants, instruction field bit positions and the issue
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    // Opcode constants
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 22;
    localparam int RT_MSB  = 21;
    localparam int RT_LSB  = 18;
    localparam int RD_MSB  = 17;
    localparam int RD_LSB  = 14;
    localparam int IMM_MSB = 13;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    // Issue FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_VALID   = 3'd4
    } of_state_t;

endpackage : risc_pkg
`default_nettype wire

// File: rtl/wb_snoop.sv
`default_nettype none
// ============================================================================
//  Module      : wb_snoop
//  Description : Watches the write-back bus while an operand read is in
//                flight. A matching write sets a hit flag and stores the
//                written data; the newest match wins. A match on the current
//                edge is forwarded combinationally so that a write landing on
//                the capture edge itself is not lost.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_snoop #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_win,
    input  logic [ADDR_WIDTH-1:0] i_idx,
    input  logic                  i_wb_en,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [WIDTH-1:0]      i_wb_data,
    input  logic                  i_clear,
    output logic                  o_hit,
    output logic [WIDTH-1:0]      o_data
);

    logic             r_hit;
    logic [WIDTH-1:0] r_data;
    logic             w_match;

    assign w_match = i_win & i_wb_en & (i_wb_addr == i_idx);

    // Record the most recent matching write-back inside the read window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit  <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_hit  <= 1'b0;
        end else if (w_match) begin
            r_hit  <= 1'b1;
            r_data <= i_wb_data;
        end
    end

    // A write on this very edge overrides anything stored earlier
    assign o_hit  = r_hit | w_match;
    assign o_data = w_match ? i_wb_data : r_data;

endmodule : wb_snoop
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Issue stage between fetch and ALU. Latches one instruction,
//                drives the register bank read ports for three cycles to
//                cover its two-edge read latency, captures operands (with
//                write-back bypass) and hands them off via valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // instruction side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_instr,
    // register bank read side
    output logic                  read_port_1,
    output logic                  read_port_2,
    output logic [ADDR_WIDTH-1:0] addr_port_1,
    output logic [ADDR_WIDTH-1:0] addr_port_2,
    input  logic [WIDTH-1:0]      dout_port_1,
    input  logic [WIDTH-1:0]      dout_port_2,
    // write-back snoop
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    // ALU side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_opcode,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic [WIDTH-1:0]      out_a,
    output logic [WIDTH-1:0]      out_b
);

    of_state_t             r_state;
    of_state_t             w_next;
    logic [WIDTH-1:0]      r_instr;
    logic [5:0]            r_opcode;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;

    logic                  w_accept;
    logic                  w_in_halt;
    logic                  w_window;
    logic                  w_is_rtype;
    logic [ADDR_WIDTH-1:0] w_rs;
    logic [ADDR_WIDTH-1:0] w_rt;
    logic [WIDTH-1:0]      w_imm_sext;
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic [WIDTH-1:0]      w_snoop_a;
    logic [WIDTH-1:0]      w_snoop_b;
    logic [WIDTH-1:0]      w_opnd_a;
    logic [WIDTH-1:0]      w_opnd_b;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    assign w_accept   = in_valid & (r_state == ST_IDLE);
    assign w_in_halt  = (in_instr[OPC_MSB:OPC_LSB] == OP_HALT);
    assign w_is_rtype = (r_instr[OPC_MSB:OPC_LSB] == OP_RTYPE);
    assign w_rs       = ADDR_WIDTH'(r_instr[RS_MSB:RS_LSB]);
    assign w_rt       = ADDR_WIDTH'(r_instr[RT_MSB:RT_LSB]);
    assign w_imm_sext = {{(WIDTH-IMM_W){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:IMM_LSB]};

    // The read window spans ISSUE, WAIT and CAPTURE
    assign w_window = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                      (r_state == ST_CAPTURE);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register; async reset discards any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; HALT needs no bank access and skips the read window
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (in_valid) w_next = w_in_halt ? ST_VALID : ST_ISSUE;
            ST_ISSUE:   w_next = ST_WAIT;
            ST_WAIT:    w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_VALID;
            ST_VALID:   if (out_ready) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Instruction latch on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= '0;
        end else if (w_accept) begin
            r_instr <= in_instr;
        end
    end

    // ------------------------------------------------------------------
    // Bank read ports: held steady over the whole window, low otherwise
    // ------------------------------------------------------------------
    assign read_port_1 = w_window;
    assign read_port_2 = w_window & w_is_rtype;
    assign addr_port_1 = read_port_1 ? w_rs : '0;
    assign addr_port_2 = read_port_2 ? w_rt : '0;

    // ------------------------------------------------------------------
    // Write-back snoop, one per operand. Flags clear outside the window so
    // every transaction starts fresh.
    // ------------------------------------------------------------------
    wb_snoop #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WIDTH)
    ) u_snoop_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_win     (read_port_1),
        .i_idx     (w_rs),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .i_clear   (~w_window),
        .o_hit     (w_hit_a),
        .o_data    (w_snoop_a)
    );

    wb_snoop #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WIDTH)
    ) u_snoop_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_win     (read_port_2),
        .i_idx     (w_rt),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .i_clear   (~w_window),
        .o_hit     (w_hit_b),
        .o_data    (w_snoop_b)
    );

    // Operand select: bypassed write-back beats bank data; I-type B is imm
    assign w_opnd_a = w_hit_a ? w_snoop_a : dout_port_1;
    assign w_opnd_b = !w_is_rtype ? w_imm_sext :
                      (w_hit_b ? w_snoop_b : dout_port_2);

    // ------------------------------------------------------------------
    // Output registers: loaded at capture, or at accept for HALT
    // ------------------------------------------------------------------
    // Load operands and control fields; held unchanged while stalled in VALID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else if (r_state == ST_CAPTURE) begin
            r_opcode <= r_instr[OPC_MSB:OPC_LSB];
            r_rd     <= ADDR_WIDTH'(r_instr[RD_MSB:RD_LSB]);
            r_a      <= w_opnd_a;
            r_b      <= w_opnd_b;
        end else if (w_accept && w_in_halt) begin
            r_opcode <= in_instr[OPC_MSB:OPC_LSB];
            r_rd     <= ADDR_WIDTH'(in_instr[RD_MSB:RD_LSB]);
            r_a      <= '0;
            r_b      <= '0;
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_VALID);
    assign out_opcode = r_opcode;
    assign out_rd     = r_rd;
    assign out_a      = r_a;
    assign out_b      = r_b;

endmodule : operand_fetch
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fetch
//  Description : Directed self-checking bench for operand_fetch, with a
//                small two-edge-latency register bank model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        read_port_1;
    logic        read_port_2;
    logic [3:0]  addr_port_1;
    logic [3:0]  addr_port_2;
    logic [31:0] dout_port_1;
    logic [31:0] dout_port_2;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [3:0]  out_rd;
    logic [31:0] out_a;
    logic [31:0] out_b;

    int n_tests = 0;
    int n_fail  = 0;

    operand_fetch #(
        .ADDR_WIDTH (4),
        .WIDTH      (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .read_port_1 (read_port_1),
        .read_port_2 (read_port_2),
        .addr_port_1 (addr_port_1),
        .addr_port_2 (addr_port_2),
        .dout_port_1 (dout_port_1),
        .dout_port_2 (dout_port_2),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_a       (out_a),
        .out_b       (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: decoders latch on the first edge, data appears
    // after the second. Preloaded while reset is held.
    logic [31:0] mem [16];
    logic [3:0]  la1, la2;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h0000_0010;
            mem[3] <= 32'h0000_0005;
            mem[4] <= 32'h0000_0007;
            mem[5] <= 32'h0000_0001;
            mem[6] <= 32'h0000_0002;
        end else if (wb_en) begin
            mem[wb_addr] <= wb_data;
        end
        if (read_port_1) la1 <= addr_port_1;
        if (read_port_2) la2 <= addr_port_2;
        dout_port_1 <= mem[la1];
        dout_port_2 <= mem[la2];
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rs,
                                       input logic [3:0] rt, input logic [3:0] rd,
                                       input logic [13:0] imm);
        return {op, rs, rt, rd, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word for a single edge; returns at the negedge after accept
    task automatic issue(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        la1 = '0; la2 = '0;
        repeat (2) @(negedge clk);

        // ---- reset state
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_rp1",       32'(read_port_1), 32'd0);
        check("rst_rp2",       32'(read_port_2), 32'd0);
        check("rst_addr1",     32'(addr_port_1), 32'd0);
        check("rst_out_a",     out_a,            32'd0);
        check("rst_out_b",     out_b,            32'd0);
        check("rst_out_rd",    32'(out_rd),      32'd0);
        check("rst_opcode",    32'(out_opcode),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- R-type rs=3 rt=4 rd=9
        issue(mk(6'd0, 4'd3, 4'd4, 4'd9, 14'd0));
        for (int k = 0; k < 3; k++) begin
            check("r_rp1",   32'(read_port_1), 32'd1);
            check("r_rp2",   32'(read_port_2), 32'd1);
            check("r_addr1", 32'(addr_port_1), 32'd3);
            check("r_addr2", 32'(addr_port_2), 32'd4);
            check("r_vld_early", 32'(out_valid), 32'd0);
            check("r_in_ready",  32'(in_ready),  32'd0);
            @(negedge clk);
        end
        check("r_valid", 32'(out_valid),   32'd1);
        check("r_rp1_off", 32'(read_port_1), 32'd0);
        check("r_out_a", out_a,            32'd5);
        check("r_out_b", out_b,            32'd7);
        check("r_out_rd", 32'(out_rd),     32'd9);
        check("r_opcode", 32'(out_opcode), 32'd0);
        @(negedge clk);
        check("r_back_idle", 32'(in_ready),  32'd1);
        check("r_vld_drop",  32'(out_valid), 32'd0);

        // ---- I-type rs=2 imm=3FFF
        issue(mk(6'd1, 4'd2, 4'd7, 4'd1, 14'h3FFF));
        for (int k = 0; k < 3; k++) begin
            check("i_rp1",   32'(read_port_1), 32'd1);
            check("i_rp2",   32'(read_port_2), 32'd0);
            check("i_addr2", 32'(addr_port_2), 32'd0);
            @(negedge clk);
        end
        check("i_valid",  32'(out_valid),  32'd1);
        check("i_out_a",  out_a,           32'h0000_0010);
        check("i_out_b",  out_b,           32'hFFFF_FFFF);
        check("i_opcode", 32'(out_opcode), 32'd1);
        check("i_out_rd", 32'(out_rd),     32'd1);
        @(negedge clk);

        // ---- snoop in WAIT, write in VALID ignored, stall
        out_ready = 1'b0;
        issue(mk(6'd0, 4'd5, 4'd6, 4'd2, 14'd0));
        @(negedge clk);                         // WAIT
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEAD_BEEF;
        @(negedge clk);                         // CAPTURE
        wb_en = 1'b0;
        @(negedge clk);                         // VALID
        check("snp_valid", 32'(out_valid), 32'd1);
        check("snp_out_a", out_a,          32'hDEAD_BEEF);
        check("snp_out_b", out_b,          32'd2);
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h1234_5678;
        @(negedge clk);
        wb_en = 1'b0;
        check("valid_wb_ignored", out_a, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready),  32'd0);
            check("stall_out_a",    out_a,          32'hDEAD_BEEF);
            check("stall_opcode",   32'(out_opcode), 32'd0);
            in_valid = (k % 2 == 0);
            in_instr = mk(6'h3F, 4'd0, 4'd0, 4'hF, 14'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stall_out_rd", 32'(out_rd), 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("release_idle",  32'(in_ready),  32'd1);
        check("release_vld",   32'(out_valid), 32'd0);

        // ---- bank holds VALID-time write; stale flag must be gone
        issue(mk(6'd0, 4'd5, 4'd4, 4'd3, 14'd0));
        repeat (3) @(negedge clk);
        check("bank_hold_a", out_a, 32'h1234_5678);
        check("bank_hold_b", out_b, 32'd7);
        @(negedge clk);

        // ---- write on the capture edge, rs==rt
        issue(mk(6'd0, 4'd5, 4'd5, 4'd3, 14'd0));
        @(negedge clk);                         // WAIT
        @(negedge clk);                         // CAPTURE
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'hAAAA_5555;
        @(negedge clk);
        wb_en = 1'b0;
        check("cap_edge_a", out_a, 32'hAAAA_5555);
        check("cap_edge_b", out_b, 32'hAAAA_5555);
        @(negedge clk);

        // ---- HALT
        issue(mk(6'h3F, 4'd3, 4'd4, 4'hC, 14'h1234));
        check("halt_valid",  32'(out_valid),   32'd1);
        check("halt_rp1",    32'(read_port_1), 32'd0);
        check("halt_rp2",    32'(read_port_2), 32'd0);
        check("halt_out_a",  out_a,            32'd0);
        check("halt_out_b",  out_b,            32'd0);
        check("halt_opcode", 32'(out_opcode),  32'h3F);
        check("halt_out_rd", 32'(out_rd),      32'hC);
        @(negedge clk);
        check("halt_idle",   32'(in_ready),    32'd1);

        // ---- async reset during WAIT
        issue(mk(6'd0, 4'd3, 4'd4, 4'd1, 14'd0));
        @(negedge clk);                         // WAIT
        check("pre_rst_rp1", 32'(read_port_1), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rp1",      32'(read_port_1), 32'd0);
        check("arst_rp2",      32'(read_port_2), 32'd0);
        check("arst_out_vld",  32'(out_valid),   32'd0);
        check("arst_in_ready", 32'(in_ready),    32'd1);
        check("arst_out_rd",   32'(out_rd),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready),  32'd1);
        check("post_rst_vld",   32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_operand_fetch
`default_nettype wire
